// File: rtl/qspi_pkg.sv
// Shared constants for the quad-SPI flash responder: opcode, phase lengths, FSM encoding.
package qspi_pkg;

  localparam int unsigned CMD_CYC       = 8;
  localparam int unsigned ADDR_CYC      = 6;
  localparam int unsigned CNT_W         = 3;
  localparam int unsigned ADDR_W_DEF    = 10;
  localparam int unsigned MODE_CYC_DEF  = 2;
  localparam int unsigned DUMMY_CYC_DEF = 4;
  localparam logic [7:0]  CMD_READ_DEF  = 8'hEB;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR   = 3'd2;
  localparam state_t ST_MODE   = 3'd3;
  localparam state_t ST_DUMMY  = 3'd4;
  localparam state_t ST_DATA   = 3'd5;
  localparam state_t ST_IGNORE = 3'd6;

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Quad-SPI pin bundle between a flash master and the responder.
interface qspi_flash_responder_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic [3:0] douten;

  modport master (output sck, output ce_n, output din, input dout, input douten);
  modport slave  (input sck, input ce_n, input din, output dout, output douten);
endinterface

// File: rtl/qspi_sck_sync.sv
// Brings sck/ce_n/din into the HCLK domain and derives sck edge pulses.
module qspi_sck_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] din,
  output logic       sck_rise_c,
  output logic       sck_fall_c,
  output logic       ce_n_s,
  output logic [3:0] din_s
);

  logic [2:0] sck_q;
  logic [1:0] ce_q;
  logic [3:0] din_m_q;
  logic [3:0] din_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q   <= 3'b000;
      ce_q    <= 2'b11;
      din_m_q <= 4'h0;
      din_s_q <= 4'h0;
    end else begin
      sck_q   <= {sck_q[1:0], sck};
      ce_q    <= {ce_q[0], ce_n};
      din_m_q <= din;
      din_s_q <= din_m_q;
    end
  end

  // sck_q[1] is the synchronized level, sck_q[2] its one-cycle delay
  assign sck_rise_c = sck_q[1] & ~sck_q[2];
  assign sck_fall_c = ~sck_q[1] & sck_q[2];
  assign ce_n_s     = ce_q[1];
  assign din_s      = din_s_q;

endmodule

// File: rtl/qspi_flash_responder.sv
// Device side of Quad I/O Fast Read (0xEB) backed by a backdoor-loadable byte memory.
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [7:0]  CMD_READ  = CMD_READ_DEF,
  parameter int unsigned MODE_CYC  = MODE_CYC_DEF,
  parameter int unsigned DUMMY_CYC = DUMMY_CYC_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  qspi_flash_responder_if.slave bus,
  input  logic                  mem_we,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [7:0]            mem_wdata,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic       sck_rise_c, sck_fall_c, ce_n_s;
  logic [3:0] din_s;

  qspi_sck_sync u_sync (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .sck        (bus.sck),
    .ce_n       (bus.ce_n),
    .din        (bus.din),
    .sck_rise_c (sck_rise_c),
    .sck_fall_c (sck_fall_c),
    .ce_n_s     (ce_n_s),
    .din_s      (din_s)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [6:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        obyte_q, obyte_d;
  logic              nib_lo_q, nib_lo_d;
  logic [1:0]        fetch_q, fetch_d;
  logic [3:0]        dout_q, dout_d;
  logic [3:0]        douten_q, douten_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;

  logic [7:0]        mem [DEPTH];
  logic [7:0]        rd_q;

  // Backdoor write port and synchronous read at the byte pointer
  always_ff @(posedge HCLK) begin
    if (mem_we && !busy_q) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[ptr_q];
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      ptr_q     <= '0;
      obyte_q   <= '0;
      nib_lo_q  <= 1'b0;
      fetch_q   <= 2'b00;
      dout_q    <= 4'h0;
      douten_q  <= 4'h0;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      ptr_q     <= ptr_d;
      obyte_q   <= obyte_d;
      nib_lo_q  <= nib_lo_d;
      fetch_q   <= fetch_d;
      dout_q    <= dout_d;
      douten_q  <= douten_d;
      busy_q    <= busy_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    obyte_d   = obyte_q;
    nib_lo_d  = nib_lo_q;
    fetch_d   = {fetch_q[0], 1'b0};
    dout_d    = dout_q;
    douten_d  = douten_q;
    busy_d    = busy_q;
    cmd_err_d = 1'b0;

    // Next byte lands two cycles after the pointer bump (pointer reg, then RAM read)
    if (fetch_q[1]) obyte_d = rd_q;

    // ce_n high dominates any same-cycle sck edge
    if (ce_n_s) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      cmd_d    = '0;
      ptr_d    = '0;
      nib_lo_d = 1'b0;
      fetch_d  = 2'b00;
      dout_d   = 4'h0;
      douten_d = 4'h0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (sck_rise_c) begin
          cmd_d   = {cmd_q[5:0], din_s[0]};
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = ST_CMD;
        end
        ST_CMD: if (sck_rise_c) begin
          cmd_d = {cmd_q[5:0], din_s[0]};
          if (cnt_q == CNT_W'(CMD_CYC - 1)) begin
            cnt_d = '0;
            if ({cmd_q, din_s[0]} == CMD_READ) begin
              state_d = ST_ADDR;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = ST_IGNORE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Address nibbles shift straight into the pointer; upper bits fall off
        ST_ADDR: if (sck_rise_c) begin
          ptr_d = {ptr_q[ADDR_W-5:0], din_s};
          if (cnt_q == CNT_W'(ADDR_CYC - 1)) begin
            cnt_d   = '0;
            state_d = ST_MODE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_MODE: if (sck_rise_c) begin
          if (cnt_q == CNT_W'(MODE_CYC - 1)) begin
            cnt_d   = '0;
            state_d = ST_DUMMY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DUMMY: if (sck_rise_c) begin
          if (cnt_q == CNT_W'(DUMMY_CYC - 1)) begin
            cnt_d    = '0;
            obyte_d  = rd_q;
            nib_lo_d = 1'b0;
            state_d  = ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DATA: if (sck_fall_c) begin
          douten_d = 4'hF;
          if (!nib_lo_q) begin
            dout_d   = obyte_q[7:4];
            nib_lo_d = 1'b1;
          end else begin
            dout_d   = obyte_q[3:0];
            nib_lo_d = 1'b0;
            ptr_d    = ptr_q + ADDR_W'(1);
            fetch_d  = 2'b01;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.dout   = dout_q;
  assign bus.douten = douten_q;
  assign busy       = busy_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed plus randomized Quad I/O Fast Read transactions checked against a byte-array model.
module tb_qspi_flash_responder;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       mem_we;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       busy;
  logic       cmd_err;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  int oe_seen = 0;
  logic watch = 1'b0;

  logic [7:0] model [0:1023];

  always #5 HCLK = ~HCLK;

  qspi_flash_responder_if bus ();

  qspi_flash_responder dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .bus       (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  always @(negedge HCLK) begin
    if (cmd_err === 1'b1) err_pulses <= err_pulses + 1;
    if (watch && bus.douten !== 4'h0) oe_seen <= oe_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge HCLK);
  endtask

  task automatic pulse(input logic [3:0] d);
    bus.din = d;
    half();
    bus.sck = 1'b1;
    half();
    bus.sck = 1'b0;
  endtask

  task automatic mem_write(input int a, input logic [7:0] d);
    @(negedge HCLK);
    mem_we = 1'b1; mem_addr = 10'(a); mem_wdata = d;
    @(negedge HCLK);
    mem_we = 1'b0;
    model[10'(a)] = d;
  endtask

  // Opcode, then up to stop_nib address nibbles; mode and dummy only if the address completes
  task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr, input int stop_nib);
    logic [2:0] r;
    logic [3:0] nib;
    bus.ce_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      r = 3'($urandom);
      bus.din = {r, op[7-i]};
      half();
      check($sformatf("busy_cmd%0d", i), 32'(busy), 32'(i > 0));
      check($sformatf("oe_cmd%0d", i), 32'(bus.douten), 32'h0);
      bus.sck = 1'b1;
      half();
      bus.sck = 1'b0;
    end
    if (op != 8'hEB) return;
    for (int n = 0; n < 6; n++) begin
      if (n == stop_nib) return;
      nib = addr[23-4*n -: 4];
      pulse(nib);
    end
    pulse(4'hA);
    pulse(4'h0);
    for (int d = 0; d < 4; d++) begin
      r = 3'($urandom);
      pulse({r, 1'b0});
    end
    check("oe_before_data", 32'(bus.douten), 32'h0);
  endtask

  task automatic read_bytes(input string tag, input int base, input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = model[10'((base + k) % 1024)];
      half();
      check($sformatf("%s_oe%0dh", tag, k), 32'(bus.douten), 32'hF);
      check($sformatf("%s_b%0dh", tag, k), 32'(bus.dout), 32'(b[7:4]));
      bus.sck = 1'b1; half(); bus.sck = 1'b0;
      half();
      check($sformatf("%s_b%0dl", tag, k), 32'(bus.dout), 32'(b[3:0]));
      bus.sck = 1'b1; half(); bus.sck = 1'b0;
    end
  endtask

  task automatic end_xfer(input string tag);
    half();
    bus.ce_n = 1'b1;
    bus.din  = 4'h0;
    half();
    check({tag, "_busy_end"}, 32'(busy), 32'h0);
    check({tag, "_oe_end"}, 32'(bus.douten), 32'h0);
    check({tag, "_dout_end"}, 32'(bus.dout), 32'h0);
  endtask

  initial begin
    int p0, o0, len;
    logic [23:0] ra;
    bus.sck = 1'b0; bus.ce_n = 1'b1; bus.din = 4'h0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    HRESETn = 1'b0;
    repeat (4) @(negedge HCLK);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_oe", 32'(bus.douten), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(cmd_err), 32'h0);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);

    for (int i = 0; i < 1024; i++) mem_write(i, 8'(i));

    send_hdr(8'hEB, 24'h000000, 6); read_bytes("a000", 0, 4); end_xfer("a000");
    send_hdr(8'hEB, 24'h000020, 6); read_bytes("a020", 32, 4); end_xfer("a020");
    send_hdr(8'hEB, 24'h00000C, 6); read_bytes("a00c", 12, 4); end_xfer("a00c");
    send_hdr(8'hEB, 24'h0003FE, 6); read_bytes("wrap", 1022, 4); end_xfer("wrap");

    // Unsupported opcode: one error pulse, outputs stay disabled while selected
    p0 = err_pulses; o0 = oe_seen;
    watch = 1'b1;
    send_hdr(8'h03, 24'h0, 6);
    for (int i = 0; i < 12; i++) pulse(4'(i));
    half();
    check("bad_busy", 32'(busy), 32'h1);
    watch = 1'b0;
    end_xfer("bad");
    check("bad_err_pulses", 32'(err_pulses - p0), 32'h1);
    check("bad_oe_seen", 32'(oe_seen - o0), 32'h0);

    // Abort mid-address, then a clean read
    send_hdr(8'hEB, 24'h123456, 3); end_xfer("abort");
    send_hdr(8'hEB, 24'h000004, 6); read_bytes("after_abort", 4, 2); end_xfer("after_abort");

    // Backdoor write while busy is dropped
    send_hdr(8'hEB, 24'h000040, 6);
    @(negedge HCLK);
    mem_we = 1'b1; mem_addr = 10'h41; mem_wdata = ~model[10'h41];
    @(negedge HCLK);
    mem_we = 1'b0;
    read_bytes("busy_wr", 64, 2); end_xfer("busy_wr");
    send_hdr(8'hEB, 24'h000041, 6); read_bytes("readback", 65, 1); end_xfer("readback");

    // Reset in the middle of data
    send_hdr(8'hEB, 24'h000100, 6); read_bytes("pre_rst", 256, 1);
    half();
    HRESETn = 1'b0;
    #1;
    check("mid_rst_dout", 32'(bus.dout), 32'h0);
    check("mid_rst_oe", 32'(bus.douten), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    bus.ce_n = 1'b1; bus.sck = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);

    // Randomized reads with idle-time memory rewrites
    for (int t = 0; t < 8; t++) begin
      for (int w = 0; w < 4; w++) mem_write(int'($urandom_range(1023)), 8'($urandom));
      ra  = 24'($urandom);
      len = int'($urandom_range(6, 1));
      send_hdr(8'hEB, ra, 6);
      read_bytes($sformatf("rnd%0d", t), int'(ra[9:0]), len);
      end_xfer($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
